// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One-hot grant vector for a requester index.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-and-find-first: first requester at or after ptr, wrapping mod 4.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 data mux.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        done,
  input  logic [N_REQ*DATA_W-1:0] din,
  output logic [N_REQ-1:0]        gnt,
  output logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       dout,
  output logic                    dout_valid,
  output logic                    timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [SEL_W-1:0] pick_winner;
  logic             pick_any;
  logic             owner_done;
  logic             owner_drop;
  logic             hold_expired;

  rr_pick u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_winner),
    .any    (pick_any)
  );

  assign owner_done   = done[sel];
  assign owner_drop   = ~req[sel];
  assign hold_expired = (hold_cnt == HOLD_LAST);

  // Arbitration FSM with registered grant, select, pointer, hold counter and timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt      <= idx_to_onehot(pick_winner);
            sel      <= pick_winner;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (owner_done || owner_drop || hold_expired) begin
            // Release; sel is kept, dout gating comes from gnt going to zero.
            gnt     <= '0;
            ptr     <= sel + SEL_W'(1);
            state   <= IDLE;
            timeout <= ~owner_done & ~owner_drop;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  assign dout_valid = |gnt;

  // Shared data mux steered by sel, forced to zero while nobody owns it.
  always_comb begin
    dout = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (dout_valid && (sel == SEL_W'(i))) begin
        dout = din[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with hand-computed expected outputs.
module tb_mux_rr_arbiter;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [3:0]    done;
  logic [4*DW-1:0] din;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          timeout;

  int total;
  int bad;

  logic [15:0] obs;
  logic [15:0] expv;

  mux_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .din        (din),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {gnt, sel, dout_valid, timeout, dout}.
  function automatic logic [15:0] mk(input logic [3:0] g, input logic [1:0] s,
                                     input logic t, input logic [7:0] d);
    return {g, s, (g != 4'b0), t, d};
  endfunction

  always_comb obs = {gnt, sel, dout_valid, timeout, dout};

  task automatic test_reset();
    rst = 1'b1; req = 4'b0; done = 4'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      expv = mk(4'b0, 2'd0, 1'b0, 8'h00);
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL reset_hold[%0d] got=%h want=%h", i, obs, expv);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expv = mk(4'b0, 2'd0, 1'b0, 8'h00);
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL reset_idle[%0d] got=%h want=%h", i, obs, expv);
      end
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    @(negedge clk);
    for (int c = 1; c <= 3; c++) begin
      expv = mk(4'b0100, 2'd2, 1'b0, 8'hA5);
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL single_grant[%0d] got=%h want=%h", c, obs, expv);
      end
      if (c == 3) done = 4'b0100;
      @(negedge clk);
    end
    expv = mk(4'b0, 2'd2, 1'b0, 8'h00);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL single_release got=%h want=%h", obs, expv);
    end
    // ptr should now be 3, so requester 3 wins an all-request round.
    done = 4'b0; req = 4'b1111;
    @(negedge clk);
    expv = mk(4'b1000, 2'd3, 1'b0, 8'hC3);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL single_ptr3 got=%h want=%h", obs, expv);
    end
    req = 4'b0;
    @(negedge clk);
    expv = mk(4'b0, 2'd3, 1'b0, 8'h00);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL single_drop got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] order [5];
    logic [7:0] data  [4];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    data  = '{8'h3C, 8'h5A, 8'hA5, 8'hC3};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      expv = mk(4'b0001 << order[k], order[k], 1'b0, data[order[k]]);
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL rotate_grant[%0d] got=%h want=%h", k, obs, expv);
      end
      done = 4'b0001 << order[k];
      @(negedge clk);
      expv = mk(4'b0, order[k], 1'b0, 8'h00);
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL rotate_bubble[%0d] got=%h want=%h", k, obs, expv);
      end
      done = 4'b0;
      if (k == 4) req = 4'b0;
    end
    @(negedge clk);
    expv = mk(4'b0, 2'd0, 1'b0, 8'h00);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL rotate_idle got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_timeout();
    req = 4'b0010;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      expv = mk(4'b0010, 2'd1, 1'b0, 8'h5A);
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL timeout_hold[%0d] got=%h want=%h", c, obs, expv);
      end
    end
    @(negedge clk);
    expv = mk(4'b0, 2'd1, 1'b1, 8'h00);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL timeout_pulse got=%h want=%h", obs, expv);
    end
    @(negedge clk);
    expv = mk(4'b0010, 2'd1, 1'b0, 8'h5A);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL timeout_regrant got=%h want=%h", obs, expv);
    end
    req = 4'b0;
    @(negedge clk);
    expv = mk(4'b0, 2'd1, 1'b0, 8'h00);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL timeout_drop got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_done_rules();
    // Stray done in IDLE must be ignored.
    done = 4'b0001;
    @(negedge clk);
    done = 4'b0; req = 4'b0001;
    @(negedge clk);
    expv = mk(4'b0001, 2'd0, 1'b0, 8'h3C);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL owner0_grant got=%h want=%h", obs, expv);
    end
    done = 4'b1000;
    @(negedge clk);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL nonowner_done got=%h want=%h", obs, expv);
    end
    done = 4'b0001; req = 4'b0101;
    @(negedge clk);
    expv = mk(4'b0, 2'd0, 1'b0, 8'h00);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL simul_release got=%h want=%h", obs, expv);
    end
    done = 4'b0;
    @(negedge clk);
    expv = mk(4'b0100, 2'd2, 1'b0, 8'hA5);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL simul_next got=%h want=%h", obs, expv);
    end
    req = 4'b0;
    @(negedge clk);
    expv = mk(4'b0, 2'd2, 1'b0, 8'h00);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL simul_drop got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_reset_mid();
    req = 4'b1000;
    @(negedge clk);
    expv = mk(4'b1000, 2'd3, 1'b0, 8'hC3);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL mid_pre got=%h want=%h", obs, expv);
    end
    rst = 1'b1; req = 4'b1001;
    @(negedge clk);
    expv = mk(4'b0, 2'd0, 1'b0, 8'h00);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL mid_reset got=%h want=%h", obs, expv);
    end
    rst = 1'b0;
    @(negedge clk);
    expv = mk(4'b0001, 2'd0, 1'b0, 8'h3C);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL mid_ptr0 got=%h want=%h", obs, expv);
    end
    req = 4'b0;
    @(negedge clk);
    expv = mk(4'b0, 2'd0, 1'b0, 8'h00);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL mid_drop got=%h want=%h", obs, expv);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 4'b0;
    done  = 4'b0;
    din   = {8'hC3, 8'hA5, 8'h5A, 8'h3C};
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_done_rules();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
